temporizador_juego: RTL

Game-length countdown timer for the Canasta game. Sits directly upstream of the cube-control FSM. It takes that FSM's one-cycle timer-start pulse, counts down a fixed number of seconds derived from the system clock, and returns a one-cycle end-of-game pulse to the FSM. It also exports the remaining time in binary and BCD for the score/time display.

---
 rtl/temporizador_juego.sv | 134 +++++++++++++
 1 files changed

// File: rtl/temporizador_juego.sv
// Game-length countdown timer: counts GAME_SECONDS game seconds of TICKS_PER_SEC clocks each.
// Latency: corriendo rises one edge after activar; tick_1s and the seconds/BCD update share an edge.
// Backpressure: none; pausa freezes the countdown, and activar in RUN restarts the game.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   activar             - one-cycle start/restart pulse from the cube-control FSM
//   pausa               - level, freezes prescaler and seconds while high in RUN
//   corriendo           - high while the countdown is running
//   tick_1s             - one-cycle pulse per elapsed game second
//   finalizado          - one-cycle end-of-game pulse back to the cube-control FSM
//   segundos_restantes  - remaining seconds, binary (zero-extended)
//   decenas, unidades   - remaining seconds, BCD tens/units
module temporizador_juego #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int GAME_SECONDS  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activar,
    input  logic       pausa,
    output logic       corriendo,
    output logic       tick_1s,
    output logic       finalizado,
    output logic [6:0] segundos_restantes,
    output logic [3:0] decenas,
    output logic [3:0] unidades
);

    localparam int              PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]      SEC_INIT  = 7'(GAME_SECONDS);
    localparam logic [3:0]      DEC_INIT  = 4'(GAME_SECONDS / 10);
    localparam logic [3:0]      UNI_INIT  = 4'(GAME_SECONDS % 10);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [6:0]     sec_q, sec_d;
    logic [3:0]     dec_q, dec_d;
    logic [3:0]     uni_q, uni_d;
    logic           tick_q, tick_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            sec_q   <= SEC_INIT;
            dec_q   <= DEC_INIT;
            uni_q   <= UNI_INIT;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sec_q   <= sec_d;
            dec_q   <= dec_d;
            uni_q   <= uni_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        dec_d   = dec_q;
        uni_d   = uni_q;
        tick_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (activar) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                    sec_d   = SEC_INIT;
                    dec_d   = DEC_INIT;
                    uni_d   = UNI_INIT;
                end
            end

            ST_RUN: begin
                if (activar) begin
                    // Restart wins over a coincident tick.
                    presc_d = '0;
                    sec_d   = SEC_INIT;
                    dec_d   = DEC_INIT;
                    uni_d   = UNI_INIT;
                end else if (!pausa) begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        // Guard keeps the count from wrapping below zero.
                        if (sec_q != 7'd0) begin
                            sec_d = sec_q - 7'd1;
                            if (uni_q == 4'd0) begin
                                uni_d = 4'd9;
                                dec_d = dec_q - 4'd1;
                            end else begin
                                uni_d = uni_q - 4'd1;
                            end
                        end
                        if (sec_q <= 7'd1) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end

            ST_DONE: begin
                // Single-cycle end marker; activar is deliberately ignored here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign corriendo          = (state_q == ST_RUN);
    assign finalizado         = (state_q == ST_DONE);
    assign tick_1s            = tick_q;
    assign segundos_restantes = sec_q;
    assign decenas            = dec_q;
    assign unidades           = uni_q;

endmodule
